// File: rtl/tow_key_conditioner_pkg.sv
// Shared types and constants for the tug-of-war key input stage.
package tow_pkg;
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} deb_state_t;

  localparam int TOW_DEBOUNCE_DEFAULT = 50000;
  localparam int TOW_DEBOUNCE_SIM     = 4;

  localparam int NUM_KEYS = 2;
  localparam int KEY_L    = 0;
  localparam int KEY_R    = 1;
endpackage

// File: rtl/tow_key_conditioner_if.sv
// Key/move bus between the player inputs and the tug-of-war input stage.
interface tow_key_conditioner_if;
  logic ce;
  logic key_l_raw;
  logic key_r_raw;
  logic L;
  logic R;
  logic key_l_db;
  logic key_r_db;

  modport master (output ce, key_l_raw, key_r_raw, input L, R, key_l_db, key_r_db);
  modport slave  (input ce, key_l_raw, key_r_raw, output L, R, key_l_db, key_r_db);
endinterface

// File: rtl/tow_key_conditioner_debounce.sv
// One key: 2-flop synchroniser, polarity normalisation and debounce FSM.
module tow_key_debounce
  import tow_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = TOW_DEBOUNCE_DEFAULT,
  parameter int RAW_ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic db,
  output logic press_evt
);
  localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic            REL_LVL = (RAW_ACTIVE_LOW != 0);

  logic [1:0]    sync_q;
  logic          lvl;
  deb_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // Both flops reset to the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= {2{REL_LVL}};
    else       sync_q <= {sync_q[0], key_raw};
  end

  assign lvl = sync_q[1] ^ REL_LVL;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_evt = 1'b0;
    unique case (state)
      RELEASED: if (lvl) begin
        state_nxt = PRESS_WAIT;
        cnt_nxt   = CW'(1);
      end
      PRESS_WAIT: begin
        if (!lvl) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_evt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESSED: if (!lvl) begin
        state_nxt = RELEASE_WAIT;
        cnt_nxt   = CW'(1);
      end
      RELEASE_WAIT: begin
        if (lvl) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign db = (state == PRESSED) || (state == RELEASE_WAIT);
endmodule

// File: rtl/tow_key_conditioner.sv
// Tug-of-war input stage: debounced keys turned into one ce-aligned move each.
// Optional TOW_SIMUL_CANCEL_EN: simultaneous L+R in one tick cancel each other.
module tow_key_conditioner
  import tow_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = TOW_DEBOUNCE_DEFAULT,
  parameter int RAW_ACTIVE_LOW  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  tow_key_conditioner_if.slave   bus
);
  logic [NUM_KEYS-1:0] raw, db, evt, pend, req, take, out_q;

  assign raw[KEY_L] = bus.key_l_raw;
  assign raw[KEY_R] = bus.key_r_raw;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    tow_key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RAW_ACTIVE_LOW  (RAW_ACTIVE_LOW)
    ) u_deb (
      .clk       (clk),
      .reset     (reset),
      .key_raw   (raw[i]),
      .db        (db[i]),
      .press_evt (evt[i])
    );
  end

  // An event landing on the ce cycle is presented directly instead of parked.
  assign req = pend | evt;

`ifdef TOW_SIMUL_CANCEL_EN
  assign take = (&req) ? '0 : req;
`else
  assign take = req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pend  <= '0;
      out_q <= '0;
    end else if (bus.ce) begin
      pend  <= '0;
      out_q <= take;
    end else begin
      pend  <= req;
    end
  end

  assign bus.L        = out_q[KEY_L];
  assign bus.R        = out_q[KEY_R];
  assign bus.key_l_db = db[KEY_L];
  assign bus.key_r_db = db[KEY_R];
endmodule

// File: tb/tb_tow_key_conditioner.sv
// Directed bench for tow_key_conditioner: DEBOUNCE_CYCLES=4, active-low keys, ce every 8 clk.
module tb_tow_key_conditioner;
  import tow_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce_mask = 1'b0;
  int   n = 0;
  int   tests = 0;
  int   fails = 0;

  int l_hi, r_hi, ldb_hi, l_rises, r_rises, l_first, r_first;
  logic l_prev = 1'b0, r_prev = 1'b0;

  tow_key_conditioner_if bus();

  tow_key_conditioner #(
    .DEBOUNCE_CYCLES (TOW_DEBOUNCE_SIM),
    .RAW_ACTIVE_LOW  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edge counter and tick generator: ce is sampled high at edges that are multiples of 8.
  initial begin
    bus.ce = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      bus.ce = (((n + 1) % 8) == 0) && !ce_mask;
    end
  end

  always @(negedge clk) begin
    if (bus.L) l_hi++;
    if (bus.R) r_hi++;
    if (bus.key_l_db) ldb_hi++;
    if (bus.L && !l_prev) begin l_rises++; if (l_first < 0) l_first = n; end
    if (bus.R && !r_prev) begin r_rises++; if (r_first < 0) r_first = n; end
    l_prev = bus.L;
    r_prev = bus.R;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    l_hi = 0; r_hi = 0; ldb_hi = 0; l_rises = 0; r_rises = 0; l_first = -1; r_first = -1;
  endtask

  task automatic wait_align(input int r);
    for (int k = 0; k < 16 && (n % 8) != r; k++) tick();
  endtask

  function automatic int ce_after(input int p);
    return ((p + 7) / 8) * 8;
  endfunction

  task automatic test_reset();
    bus.key_l_raw = 1'b1;
    bus.key_r_raw = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    tests++; if (bus.L !== 1'b0) begin fails++; $display("FAIL reset_L: got %b want 0", bus.L); end
    tests++; if (bus.R !== 1'b0) begin fails++; $display("FAIL reset_R: got %b want 0", bus.R); end
    tests++; if (bus.key_l_db !== 1'b0) begin fails++; $display("FAIL reset_ldb: got %b want 0", bus.key_l_db); end
    tests++; if (bus.key_r_db !== 1'b0) begin fails++; $display("FAIL reset_rdb: got %b want 0", bus.key_r_db); end
    reset = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_single_press();
    int t;
    wait_align(3);
    clear_mon();
    t = n + 1;
    bus.key_l_raw = 1'b0;
    repeat (20) tick();
    bus.key_l_raw = 1'b1;
    repeat (40) tick();
    tests++; if (l_rises !== 1) begin fails++; $display("FAIL press_rises: got %0d want 1", l_rises); end
    tests++; if (l_first !== ce_after(t + 6)) begin fails++; $display("FAIL press_start: got %0d want %0d", l_first, ce_after(t + 6)); end
    tests++; if (l_hi !== 8) begin fails++; $display("FAIL press_len: got %0d want 8", l_hi); end
    tests++; if (r_hi !== 0) begin fails++; $display("FAIL press_R_quiet: got %0d want 0", r_hi); end
    tests++; if (ldb_hi !== 20) begin fails++; $display("FAIL press_db_len: got %0d want 20", ldb_hi); end
  endtask

  task automatic test_bounce();
    clear_mon();
    for (int i = 0; i < 15; i++) begin
      bus.key_l_raw = (i % 2) != 0;
      repeat (2) tick();
    end
    bus.key_l_raw = 1'b1;
    repeat (30) tick();
    tests++; if (l_hi !== 0) begin fails++; $display("FAIL bounce_L: got %0d want 0", l_hi); end
    tests++; if (ldb_hi !== 0) begin fails++; $display("FAIL bounce_db: got %0d want 0", ldb_hi); end
  endtask

  task automatic test_hold();
    int t;
    wait_align(1);
    clear_mon();
    t = n + 1;
    bus.key_l_raw = 1'b0;
    repeat (200) tick();
    bus.key_l_raw = 1'b1;
    repeat (20) tick();
    tests++; if (l_rises !== 1) begin fails++; $display("FAIL hold_rises: got %0d want 1", l_rises); end
    tests++; if (l_hi !== 8) begin fails++; $display("FAIL hold_len: got %0d want 8", l_hi); end
    tests++; if (l_first !== t + 6) begin fails++; $display("FAIL hold_start: got %0d want %0d", l_first, t + 6); end
    tests++; if (ldb_hi !== 200) begin fails++; $display("FAIL hold_db_len: got %0d want 200", ldb_hi); end
    bus.key_l_raw = 1'b0;
    repeat (10) tick();
    bus.key_l_raw = 1'b1;
    repeat (30) tick();
    tests++; if (l_rises !== 2) begin fails++; $display("FAIL repress_rises: got %0d want 2", l_rises); end
    tests++; if (l_hi !== 16) begin fails++; $display("FAIL repress_len: got %0d want 16", l_hi); end
  endtask

  task automatic test_back_to_back();
    wait_align(1);
    ce_mask = 1'b1;
    clear_mon();
    bus.key_l_raw = 1'b0;
    repeat (6) tick();
    bus.key_l_raw = 1'b1;
    repeat (12) tick();
    bus.key_l_raw = 1'b0;
    repeat (6) tick();
    bus.key_l_raw = 1'b1;
    repeat (10) tick();
    tests++; if (l_rises !== 0) begin fails++; $display("FAIL b2b_early: got %0d want 0", l_rises); end
    ce_mask = 1'b0;
    repeat (30) tick();
    tests++; if (l_rises !== 1) begin fails++; $display("FAIL b2b_rises: got %0d want 1", l_rises); end
    tests++; if (l_hi !== 8) begin fails++; $display("FAIL b2b_len: got %0d want 8", l_hi); end
  endtask

  task automatic test_simultaneous();
    int t;
    wait_align(3);
    clear_mon();
    t = n + 1;
    bus.key_l_raw = 1'b0;
    bus.key_r_raw = 1'b0;
    repeat (8) tick();
    bus.key_l_raw = 1'b1;
    bus.key_r_raw = 1'b1;
    repeat (30) tick();
`ifdef TOW_SIMUL_CANCEL_EN
    tests++; if (l_hi !== 0) begin fails++; $display("FAIL simul_cancel_L: got %0d want 0", l_hi); end
    tests++; if (r_hi !== 0) begin fails++; $display("FAIL simul_cancel_R: got %0d want 0", r_hi); end
`else
    tests++; if (l_hi !== 8) begin fails++; $display("FAIL simul_L_len: got %0d want 8", l_hi); end
    tests++; if (r_hi !== 8) begin fails++; $display("FAIL simul_R_len: got %0d want 8", r_hi); end
    tests++; if (l_first !== ce_after(t + 6)) begin fails++; $display("FAIL simul_L_start: got %0d want %0d", l_first, ce_after(t + 6)); end
    tests++; if (r_first !== ce_after(t + 6)) begin fails++; $display("FAIL simul_R_start: got %0d want %0d", r_first, ce_after(t + 6)); end
`endif
  endtask

  task automatic test_reset_pending();
    int t, e;
    // Pending move wiped by reset before the tick arrives.
    wait_align(1);
    ce_mask = 1'b1;
    bus.key_l_raw = 1'b0;
    repeat (6) tick();
    bus.key_l_raw = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (bus.key_l_db !== 1'b0) begin fails++; $display("FAIL rst_pend_db: got %b want 0", bus.key_l_db); end
    clear_mon();
    ce_mask = 1'b0;
    repeat (30) tick();
    tests++; if (l_hi !== 0) begin fails++; $display("FAIL rst_pend_L: got %0d want 0", l_hi); end
    // Reset while L is being presented.
    wait_align(3);
    t = n + 1;
    e = ce_after(t + 6);
    bus.key_l_raw = 1'b0;
    repeat (8) tick();
    bus.key_l_raw = 1'b1;
    for (int k = 0; k < 64 && n != e + 1; k++) tick();
    tests++; if (bus.L !== 1'b1) begin fails++; $display("FAIL rst_out_pre: got %b want 1", bus.L); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (bus.L !== 1'b0) begin fails++; $display("FAIL rst_out_L: got %b want 0", bus.L); end
    tests++; if (bus.R !== 1'b0) begin fails++; $display("FAIL rst_out_R: got %b want 0", bus.R); end
    clear_mon();
    repeat (20) tick();
    tests++; if (l_hi !== 0) begin fails++; $display("FAIL rst_out_late: got %0d want 0", l_hi); end
  endtask

  initial begin
    bus.key_l_raw = 1'b1;
    bus.key_r_raw = 1'b1;
    clear_mon();
    test_reset();
    test_single_press();
    test_bounce();
    test_hold();
    test_back_to_back();
    test_simultaneous();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
